// File: rtl/car_rom_arb.sv
// Two-car arbiter in front of the shared car sprite ROM: grants one pixel fetch per cycle, returns pixels to the owner.
// Define CAR_ARB_FIXED_PRIO_EN to make car 0 always win contention (no round-robin pointer).
module car_rom_arb #(
   parameter int DATA_W = 12
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic [3:0]        dir0,
   input  logic [3:0]        dir1,
   input  logic [4:0]        x0,
   input  logic [4:0]        y0,
   input  logic [4:0]        x1,
   input  logic [4:0]        y1,
   output logic              gnt0,
   output logic              gnt1,
   output logic [3:0]        rom_dir,
   output logic [4:0]        rom_x,
   output logic [4:0]        rom_y,
   input  logic [DATA_W-1:0] rom_rgb,
   output logic [DATA_W-1:0] rgb0,
   output logic [DATA_W-1:0] rgb1,
   output logic              rgb0_valid,
   output logic              rgb1_valid
);

   logic              xfer;
   logic [3:0]        rom_dir_d, rom_dir_q;
   logic [4:0]        rom_x_d, rom_x_q;
   logic [4:0]        rom_y_d, rom_y_q;
   logic              vld_p1_d, vld_p1_q;
   logic              own_p1_d, own_p1_q;
   logic [DATA_W-1:0] rgb0_d, rgb0_q;
   logic [DATA_W-1:0] rgb1_d, rgb1_q;
   logic              vld0_p2_d, vld0_p2_q;
   logic              vld1_p2_d, vld1_p2_q;

`ifdef CAR_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         gnt0 = req0;
         gnt1 = req1 && !req0;
      end
   end
`else
   // last_q = 1 means car 1 owned the most recent transfer, so car 0 wins the next contention
   logic last_d, last_q;

   always_comb begin
      gnt0   = 1'b0;
      gnt1   = 1'b0;
      last_d = last_q;
      if (!rst) begin
         if (req0 && req1) begin
            gnt0 = last_q;
            gnt1 = !last_q;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
      if (gnt0 || gnt1) begin
         last_d = gnt1;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   // Stage p1: ROM address, owner tag and stage-valid
   always_comb begin
      xfer      = gnt0 || gnt1;
      rom_dir_d = rom_dir_q;
      rom_x_d   = rom_x_q;
      rom_y_d   = rom_y_q;
      own_p1_d  = own_p1_q;
      vld_p1_d  = xfer;
      if (xfer) begin
         own_p1_d  = gnt1;
         rom_dir_d = gnt1 ? dir1 : dir0;
         rom_x_d   = gnt1 ? x1 : x0;
         rom_y_d   = gnt1 ? y1 : y0;
      end
   end

   // Stage p2: capture ROM pixel into the owner's return register
   always_comb begin
      rgb0_d    = rgb0_q;
      rgb1_d    = rgb1_q;
      vld0_p2_d = 1'b0;
      vld1_p2_d = 1'b0;
      if (vld_p1_q) begin
         if (own_p1_q) begin
            rgb1_d    = rom_rgb;
            vld1_p2_d = 1'b1;
         end else begin
            rgb0_d    = rom_rgb;
            vld0_p2_d = 1'b1;
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         rom_dir_q <= '0;
         rom_x_q   <= '0;
         rom_y_q   <= '0;
         own_p1_q  <= 1'b0;
         vld_p1_q  <= 1'b0;
         rgb0_q    <= '0;
         rgb1_q    <= '0;
         vld0_p2_q <= 1'b0;
         vld1_p2_q <= 1'b0;
      end else begin
         rom_dir_q <= rom_dir_d;
         rom_x_q   <= rom_x_d;
         rom_y_q   <= rom_y_d;
         own_p1_q  <= own_p1_d;
         vld_p1_q  <= vld_p1_d;
         rgb0_q    <= rgb0_d;
         rgb1_q    <= rgb1_d;
         vld0_p2_q <= vld0_p2_d;
         vld1_p2_q <= vld1_p2_d;
      end
   end

   assign rom_dir    = rom_dir_q;
   assign rom_x      = rom_x_q;
   assign rom_y      = rom_y_q;
   assign rgb0       = rgb0_q;
   assign rgb1       = rgb1_q;
   assign rgb0_valid = vld0_p2_q;
   assign rgb1_valid = vld1_p2_q;

endmodule

// File: tb/tb_car_rom_arb.sv
// Directed bench for car_rom_arb (default round-robin build) with a small combinational sprite ROM model.
module tb_car_rom_arb;

   logic        pclk;
   logic        rst;
   logic        req0, req1;
   logic [3:0]  dir0, dir1;
   logic [4:0]  x0, y0, x1, y1;
   logic        gnt0, gnt1;
   logic [3:0]  rom_dir;
   logic [4:0]  rom_x, rom_y;
   logic [11:0] rom_rgb;
   logic [11:0] rgb0, rgb1;
   logic        rgb0_valid, rgb1_valid;

   int checks = 0;
   int errors = 0;

   car_rom_arb dut (
      .pclk(pclk), .rst(rst),
      .req0(req0), .req1(req1),
      .dir0(dir0), .dir1(dir1),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rom_dir(rom_dir), .rom_x(rom_x), .rom_y(rom_y),
      .rom_rgb(rom_rgb),
      .rgb0(rgb0), .rgb1(rgb1),
      .rgb0_valid(rgb0_valid), .rgb1_valid(rgb1_valid)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   function automatic logic [11:0] rom_f(input logic [3:0] d, input logic [4:0] x, input logic [4:0] y);
      if (d == 4'd5 && x == 5'd3 && y == 5'd7) return 12'h888;
      return {d, y[2:0], x};
   endfunction

   assign rom_rgb = rom_f(rom_dir, rom_x, rom_y);

   typedef struct {
      logic       req0, req1;
      logic [3:0] dir0; logic [4:0] x0, y0;
      logic [3:0] dir1; logic [4:0] x1, y1;
      logic       g0, g1;
      logic [3:0] edir; logic [4:0] ex, ey;
      logic       v0, v1;
      logic [11:0] rgb0, rgb1;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic r1, input logic [3:0] d0, input logic [4:0] a0,
                        input logic [4:0] b0, input logic [3:0] d1, input logic [4:0] a1, input logic [4:0] b1);
      req0 = r0; req1 = r1;
      dir0 = d0; x0 = a0; y0 = b0;
      dir1 = d1; x1 = a1; y1 = b1;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b1, 1'b1, 4'd2, 5'd4, 5'd1, 4'd9, 5'd10, 5'd6);

      //            r0    r1    dir0  x0     y0     dir1  x1      y1     g0    g1    rdir  rx      ry     v0    v1    rgb0     rgb1
      tbl[0]  = '{1'b1, 1'b1, 4'd2, 5'd4, 5'd1, 4'd9, 5'd10, 5'd6, 1'b1, 1'b0, 4'd0, 5'd0,  5'd0, 1'b0, 1'b0, 12'h000, 12'h000};
      tbl[1]  = '{1'b1, 1'b1, 4'd2, 5'd4, 5'd1, 4'd9, 5'd10, 5'd6, 1'b0, 1'b1, 4'd2, 5'd4,  5'd1, 1'b0, 1'b0, 12'h000, 12'h000};
      tbl[2]  = '{1'b1, 1'b1, 4'd2, 5'd4, 5'd1, 4'd9, 5'd10, 5'd6, 1'b1, 1'b0, 4'd9, 5'd10, 5'd6, 1'b1, 1'b0, 12'h224, 12'h000};
      tbl[3]  = '{1'b1, 1'b1, 4'd2, 5'd4, 5'd1, 4'd9, 5'd10, 5'd6, 1'b0, 1'b1, 4'd2, 5'd4,  5'd1, 1'b0, 1'b1, 12'h224, 12'h9CA};
      tbl[4]  = '{1'b1, 1'b0, 4'd5, 5'd3, 5'd7, 4'd9, 5'd10, 5'd6, 1'b1, 1'b0, 4'd9, 5'd10, 5'd6, 1'b1, 1'b0, 12'h224, 12'h9CA};
      tbl[5]  = '{1'b0, 1'b0, 4'd5, 5'd3, 5'd7, 4'd9, 5'd10, 5'd6, 1'b0, 1'b0, 4'd5, 5'd3,  5'd7, 1'b0, 1'b1, 12'h224, 12'h9CA};
      tbl[6]  = '{1'b0, 1'b0, 4'd5, 5'd3, 5'd7, 4'd9, 5'd10, 5'd6, 1'b0, 1'b0, 4'd5, 5'd3,  5'd7, 1'b1, 1'b0, 12'h888, 12'h9CA};
      tbl[7]  = '{1'b0, 1'b0, 4'd5, 5'd3, 5'd7, 4'd9, 5'd10, 5'd6, 1'b0, 1'b0, 4'd5, 5'd3,  5'd7, 1'b0, 1'b0, 12'h888, 12'h9CA};
      tbl[8]  = '{1'b0, 1'b0, 4'd5, 5'd3, 5'd7, 4'd9, 5'd10, 5'd6, 1'b0, 1'b0, 4'd5, 5'd3,  5'd7, 1'b0, 1'b0, 12'h888, 12'h9CA};
      tbl[9]  = '{1'b0, 1'b0, 4'd5, 5'd3, 5'd7, 4'd9, 5'd10, 5'd6, 1'b0, 1'b0, 4'd5, 5'd3,  5'd7, 1'b0, 1'b0, 12'h888, 12'h9CA};
      tbl[10] = '{1'b1, 1'b1, 4'd5, 5'd3, 5'd7, 4'd3, 5'd31, 5'd0, 1'b0, 1'b1, 4'd5, 5'd3,  5'd7, 1'b0, 1'b0, 12'h888, 12'h9CA};
      tbl[11] = '{1'b0, 1'b0, 4'd5, 5'd3, 5'd7, 4'd3, 5'd31, 5'd0, 1'b0, 1'b0, 4'd3, 5'd31, 5'd0, 1'b0, 1'b0, 12'h888, 12'h9CA};
      tbl[12] = '{1'b0, 1'b0, 4'd5, 5'd3, 5'd7, 4'd3, 5'd31, 5'd0, 1'b0, 1'b0, 4'd3, 5'd31, 5'd0, 1'b0, 1'b1, 12'h888, 12'h31F};

      // Reset held with both cars requesting
      for (int i = 0; i < 2; i++) begin
         @(posedge pclk); #1; #4;
         chk($sformatf("rst%0d_gnt0", i), {31'd0, gnt0}, 32'd0);
         chk($sformatf("rst%0d_gnt1", i), {31'd0, gnt1}, 32'd0);
         chk($sformatf("rst%0d_rom", i), {18'd0, rom_dir, rom_x, rom_y}, 32'd0);
         chk($sformatf("rst%0d_valids", i), {30'd0, rgb0_valid, rgb1_valid}, 32'd0);
         chk($sformatf("rst%0d_rgb", i), {8'd0, rgb0, rgb1}, 32'd0);
      end

      // Contention, single request, idle hold, pointer retention
      for (int i = 0; i < 13; i++) begin
         @(posedge pclk); #1;
         rst = 1'b0;
         drive(tbl[i].req0, tbl[i].req1, tbl[i].dir0, tbl[i].x0, tbl[i].y0, tbl[i].dir1, tbl[i].x1, tbl[i].y1);
         #4;
         chk($sformatf("v%0d_gnt0", i), {31'd0, gnt0}, {31'd0, tbl[i].g0});
         chk($sformatf("v%0d_gnt1", i), {31'd0, gnt1}, {31'd0, tbl[i].g1});
         chk($sformatf("v%0d_rom", i), {18'd0, rom_dir, rom_x, rom_y}, {18'd0, tbl[i].edir, tbl[i].ex, tbl[i].ey});
         chk($sformatf("v%0d_v0", i), {31'd0, rgb0_valid}, {31'd0, tbl[i].v0});
         chk($sformatf("v%0d_v1", i), {31'd0, rgb1_valid}, {31'd0, tbl[i].v1});
         chk($sformatf("v%0d_rgb0", i), {20'd0, rgb0}, {20'd0, tbl[i].rgb0});
         chk($sformatf("v%0d_rgb1", i), {20'd0, rgb1}, {20'd0, tbl[i].rgb1});
      end

      // Streaming: 32 back-to-back fetches for car 1
      begin
         int pulses;
         pulses = 0;
         for (int s = 0; s < 34; s++) begin
            @(posedge pclk); #1;
            drive(1'b0, (s < 32), 4'd5, 5'd3, 5'd7, 4'd7, s[4:0], 5'd2);
            #4;
            if (s < 32) chk($sformatf("str%0d_gnt1", s), {31'd0, gnt1}, 32'd1);
            chk($sformatf("str%0d_v0", s), {31'd0, rgb0_valid}, 32'd0);
            if (s >= 2) begin
               chk($sformatf("str%0d_v1", s), {31'd0, rgb1_valid}, 32'd1);
               chk($sformatf("str%0d_rgb1", s), {20'd0, rgb1}, {20'd0, rom_f(4'd7, 5'(s - 2), 5'd2)});
            end else begin
               chk($sformatf("str%0d_v1", s), {31'd0, rgb1_valid}, 32'd0);
            end
            if (rgb1_valid) pulses++;
         end
         chk("str_pulses", pulses, 32);
         chk("str_rgb0_hold", {20'd0, rgb0}, 32'h888);
      end

      // Reset asserted the edge after a car 1 transfer
      @(posedge pclk); #1;
      drive(1'b0, 1'b1, 4'd5, 5'd3, 5'd7, 4'd4, 5'd1, 5'd1);
      #4;
      chk("mf_xfer_gnt1", {31'd0, gnt1}, 32'd1);
      @(posedge pclk); #1;
      rst = 1'b1;
      req0 = 1'b1;
      #4;
      chk("mf_rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
      @(posedge pclk); #1;
      rst = 1'b0;
      #4;
      chk("mf_v1", {31'd0, rgb1_valid}, 32'd0);
      chk("mf_rgb1", {20'd0, rgb1}, 32'd0);
      chk("mf_rgb0", {20'd0, rgb0}, 32'd0);
      chk("mf_rom", {18'd0, rom_dir, rom_x, rom_y}, 32'd0);
      chk("mf_first_gnt0", {30'd0, gnt0, gnt1}, 32'd2);
      @(posedge pclk); #1;
      drive(1'b0, 1'b0, 4'd5, 5'd3, 5'd7, 4'd4, 5'd1, 5'd1);
      #4;
      chk("mf_post_v", {30'd0, rgb0_valid, rgb1_valid}, 32'd0);
      chk("mf_post_rom", {18'd0, rom_dir, rom_x, rom_y}, {18'd0, 4'd5, 5'd3, 5'd7});
      @(posedge pclk); #1; #4;
      chk("mf_post_v0", {30'd0, rgb0_valid, rgb1_valid}, 32'd2);
      chk("mf_post_rgb0", {20'd0, rgb0}, 32'h888);
      chk("mf_post_rgb1", {20'd0, rgb1}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
